// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with wait-state timeout,
// halt and fault handling. Define PERF_CNT_EN to build the instret/stall_cycles counters.
module mc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             dec_write_reg,
    input  logic             dec_write_mem,
    input  logic             dec_read_ram,
    input  logic [1:0]       dec_jmp,
    input  logic             dec_branch,
    input  logic             dec_invalid,
    input  logic             alu_ne,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 at_limit;

    assign at_limit = (wait_q == TIMEOUT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        halted   = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                // An ack on the limit cycle takes priority over the timeout.
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (at_limit) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: state_d = dec_invalid ? StFault : StExec;
            StExec:   state_d = (dec_read_ram || dec_write_mem) ? StMem : StWb;
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = dec_write_mem;
                if (dmem_ack) begin
                    state_d = StWb;
                end else if (at_limit) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb: begin
                reg_we = dec_write_reg;
                pc_we  = 1'b1;
                if (dec_jmp == 2'b01 || dec_jmp == 2'b10) begin
                    pc_sel = 2'b10;
                end else if (dec_jmp == 2'b11) begin
                    pc_sel = 2'b11;
                end else if (dec_branch && alu_ne) begin
                    pc_sel = 2'b01;
                end
                state_d = halt ? StHalt : StFetch;
            end
            StHalt: begin
                halted = 1'b1;
                if (!halt) begin
                    state_d = StFetch;
                end
            end
            StFault: fault = 1'b1;
            default: state_d = StFault;
        endcase
    end

    assign state = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instret_q, stall_q;
    logic             stall_now;

    assign stall_now = ((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == StWb) begin
                instret_q <= instret_q + 1'b1;
            end
            if (stall_now) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign instret      = instret_q;
    assign stall_cycles = stall_q;
`else
    assign instret      = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: each instruction is expanded into an expected per-cycle trace
// from the sequencing rules, and a negedge compare process checks the DUT against it.
module tb_mc_sequencer;

    localparam int TO    = 255;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst, halt, imem_ack, dmem_ack;
    logic             dec_write_reg, dec_write_mem, dec_read_ram, dec_branch, dec_invalid, alu_ne;
    logic [1:0]       dec_jmp;
    logic             imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, fault;
    logic [1:0]       pc_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret, stall_cycles;

    always #5 clk = ~clk;

    mc_sequencer #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dec_write_reg(dec_write_reg), .dec_write_mem(dec_write_mem),
        .dec_read_ram(dec_read_ram), .dec_jmp(dec_jmp), .dec_branch(dec_branch),
        .dec_invalid(dec_invalid), .alu_ne(alu_ne),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
        .halted(halted), .fault(fault), .instret(instret), .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic       imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we;
        logic [1:0] pc_sel;
        logic [2:0] state;
        logic       halted, fault;
    } outv_t;

    typedef struct packed {
        logic       wr, wm, rd;
        logic [1:0] jmp;
        logic       br, inv, ne;
    } dec_t;

    outv_t act;
    assign act = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, state, halted, fault};

    outv_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc_no = 0;
    longint instret_m = 0;
    longint stall_m   = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outv_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got=%b exp=%b (req,irwe,dreq,dwe,rwe,pcwe,sel,st,hlt,flt)",
                         cyc_no, act, e);
            end
            cyc_no++;
        end
    end

    function automatic outv_t mk(input logic [2:0] st);
        outv_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic logic [1:0] exp_sel(input dec_t d);
        if (d.jmp == 2'b01 || d.jmp == 2'b10) return 2'b10;
        if (d.jmp == 2'b11) return 2'b11;
        if (d.br && d.ne) return 2'b01;
        return 2'b00;
    endfunction

    task automatic tick(input outv_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef PERF_CNT_EN
        check_val({name, "_instret"}, longint'(instret), instret_m);
        check_val({name, "_stall"}, longint'(stall_cycles), stall_m);
`else
        check_val({name, "_instret"}, longint'(instret), 0);
        check_val({name, "_stall"}, longint'(stall_cycles), 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        instret_m = 0;
        stall_m   = 0;
    endtask

    task automatic fault_cycles(input int n);
        outv_t e;
        e = mk(3'd6);
        e.fault = 1'b1;
        for (int i = 0; i < n; i++) tick(e);
    endtask

    // Runs one instruction; waits greater than TO mean the ack never comes.
    task automatic run_instr(input dec_t d, input int fwait, input int mwait,
                             input bit halt_exec, input int halt_hold, output int ncyc);
        outv_t e;
        int    n;
        ncyc = 0;
        dec_write_reg = d.wr; dec_write_mem = d.wm; dec_read_ram = d.rd;
        dec_jmp = d.jmp; dec_branch = d.br; dec_invalid = d.inv; alu_ne = d.ne;
        halt = 1'b0;
        n = (fwait > TO) ? TO + 1 : fwait;
        e = mk(3'd0);
        e.imem_req = 1'b1;
        imem_ack = 1'b0;
        for (int i = 0; i < n; i++) begin tick(e); ncyc++; end
        stall_m += n;
        if (fwait > TO) begin fault_cycles(20); return; end
        imem_ack = 1'b1;
        e.ir_we = 1'b1;
        tick(e); ncyc++;
        imem_ack = 1'b0;
        tick(mk(3'd1)); ncyc++;
        if (d.inv) begin fault_cycles(20); return; end
        if (halt_exec) halt = 1'b1;
        tick(mk(3'd2)); ncyc++;
        if (d.rd || d.wm) begin
            n = (mwait > TO) ? TO + 1 : mwait;
            e = mk(3'd3);
            e.dmem_req = 1'b1;
            e.dmem_we  = d.wm;
            for (int i = 0; i < n; i++) begin tick(e); ncyc++; end
            stall_m += n;
            if (mwait > TO) begin fault_cycles(20); return; end
            dmem_ack = 1'b1;
            tick(e); ncyc++;
            dmem_ack = 1'b0;
        end
        e = mk(3'd4);
        e.reg_we = d.wr;
        e.pc_we  = 1'b1;
        e.pc_sel = exp_sel(d);
        tick(e); ncyc++;
        instret_m++;
        if (halt_exec) begin
            e = mk(3'd5);
            e.halted = 1'b1;
            for (int i = 0; i < halt_hold; i++) tick(e);
            halt = 1'b0;
            tick(e);
        end
    endtask

    localparam dec_t ADDU = '{wr: 1'b1, wm: 1'b0, rd: 1'b0, jmp: 2'b00, br: 1'b0, inv: 1'b0, ne: 1'b0};
    localparam dec_t LW   = '{wr: 1'b1, wm: 1'b0, rd: 1'b1, jmp: 2'b00, br: 1'b0, inv: 1'b0, ne: 1'b0};
    localparam dec_t SW   = '{wr: 1'b0, wm: 1'b1, rd: 1'b0, jmp: 2'b00, br: 1'b0, inv: 1'b0, ne: 1'b0};
    localparam dec_t BNE1 = '{wr: 1'b0, wm: 1'b0, rd: 1'b0, jmp: 2'b00, br: 1'b1, inv: 1'b0, ne: 1'b1};
    localparam dec_t BNE0 = '{wr: 1'b0, wm: 1'b0, rd: 1'b0, jmp: 2'b00, br: 1'b1, inv: 1'b0, ne: 1'b0};
    localparam dec_t JR   = '{wr: 1'b0, wm: 1'b0, rd: 1'b0, jmp: 2'b11, br: 1'b0, inv: 1'b0, ne: 1'b1};
    localparam dec_t JAL  = '{wr: 1'b1, wm: 1'b0, rd: 1'b0, jmp: 2'b01, br: 1'b1, inv: 1'b0, ne: 1'b1};
    localparam dec_t JJ   = '{wr: 1'b0, wm: 1'b0, rd: 1'b0, jmp: 2'b10, br: 1'b0, inv: 1'b0, ne: 1'b0};
    localparam dec_t BAD  = '{wr: 1'b1, wm: 1'b0, rd: 1'b0, jmp: 2'b00, br: 1'b0, inv: 1'b1, ne: 1'b0};

    initial begin
        int n;
        rst = 1'b1; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_write_reg = 1'b0; dec_write_mem = 1'b0; dec_read_ram = 1'b0;
        dec_jmp = 2'b00; dec_branch = 1'b0; dec_invalid = 1'b0; alu_ne = 1'b0;

        do_reset();
        check_cnt("reset");
        run_instr(ADDU, 0, 0, 1'b0, 0, n);
        check_val("addu_cycles", n, 4);
        check_cnt("addu");

        do_reset();
        run_instr(LW, 0, 3, 1'b0, 0, n);
        check_val("lw_cycles", n, 8);
`ifdef PERF_CNT_EN
        check_val("lw_stall_lit", longint'(stall_cycles), 3);
`endif
        check_cnt("lw");
        run_instr(SW, 0, 0, 1'b0, 0, n);
        check_val("sw_cycles", n, 5);
        run_instr(BNE1, 0, 0, 1'b0, 0, n);
        run_instr(BNE0, 0, 0, 1'b0, 0, n);
        run_instr(JR, 0, 0, 1'b0, 0, n);
        run_instr(JAL, 0, 0, 1'b0, 0, n);
        run_instr(JJ, 2, 0, 1'b0, 0, n);
        check_val("fetch_wait_cycles", n, 6);
        check_cnt("branches");

        run_instr(BAD, 1, 0, 1'b0, 0, n);
        do_reset();
        check_cnt("after_fault_reset");
        run_instr(ADDU, 0, 0, 1'b0, 0, n);

        do_reset();
        run_instr(ADDU, 300, 0, 1'b0, 0, n);
        check_val("timeout_fetch_cycles", n, 256);
        check_cnt("timeout_fetch");
        do_reset();
        run_instr(ADDU, 255, 0, 1'b0, 0, n);
        check_val("ack_at_limit_cycles", n, 259);
        check_cnt("ack_at_limit");
        run_instr(LW, 0, 300, 1'b0, 0, n);
        do_reset();
        run_instr(SW, 0, 255, 1'b0, 0, n);
        check_cnt("mem_ack_at_limit");

        do_reset();
        run_instr(ADDU, 0, 0, 1'b1, 5, n);
`ifdef PERF_CNT_EN
        check_val("halt_instret_lit", longint'(instret), 1);
`endif
        check_cnt("halt");
        run_instr(LW, 1, 1, 1'b0, 0, n);
        check_cnt("after_halt");

        while (exp_q.size() > 0) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
